// File: rtl/snake_pkg.sv
// Shared definitions for the snake game control plane.
//   - direction codes (DIR_UP/DOWN/LEFT/RIGHT)
//   - game state encoding (ST_IDLE/RUN/PAUSE/OVER)
//   - opposite(): the direction a snake may never reverse into
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Up/down and left/right differ only in bit 0.
  function automatic logic [1:0] opposite(input logic [1:0] dir);
    return dir ^ 2'b01;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Synchronous circular FIFO of 2-bit direction entries.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, wr_dir      write wr_dir at the tail (accepted when not full, or
//                     when a pop happens in the same cycle)
//   pop               remove the head entry (ignored when empty)
//   flush             synchronous clear, overrides push/pop
//   head, tail        oldest and newest entries (tail valid when count>0)
//   count             occupancy, 0..QDEPTH
import snake_pkg::*;

module dir_fifo #(
  parameter int QDEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [1:0]                 wr_dir,
  output logic [1:0]                 head,
  output logic [1:0]                 tail,
  output logic [$clog2(QDEPTH):0]    count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [1:0]    mem_r [QDEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify push/pop against occupancy; a full FIFO takes a push only with a pop.
  always_comb begin
    do_pop_s  = pop && (count_r != CW'(0));
    do_push_s = push && ((count_r < CW'(QDEPTH)) || do_pop_s);
  end

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= 2'b00;
      end
    end else if (flush) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_dir;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign tail  = mem_r[wr_ptr_r - PW'(1)];
  assign count = count_r;

endmodule

// File: rtl/snake_input_scheduler.sv
// Control-plane scheduler between the keyboard/button decoders and the game
// core. Merges event pulses, runs the IDLE/RUN/PAUSE/OVER state machine and
// queues filtered direction commands so that one is applied per game tick.
// Ports:
//   kb_*/btn_*        event pulses and direction codes from the two front-ends
//   game_tick         snake moves one cell (pops a queued direction in RUN)
//   game_over         collision pulse
//   cur_dir           direction applied at the current move
//   dir_changed       pulse, cur_dir updated from the queue
//   dir_dropped       pulse, a direction event was discarded
//   game_state, run   current state, run = (state == RUN)
//   game_reset        pulse, game core reinitialises
//   q_count           direction queue occupancy
// All outputs are registered.
import snake_pkg::*;

module snake_input_scheduler #(
  parameter int QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               kb_dir,
  input  logic                     kb_dir_valid,
  input  logic                     kb_start_pause,
  input  logic                     kb_reset,
  input  logic [1:0]               btn_dir,
  input  logic                     btn_dir_valid,
  input  logic                     btn_start_pause,
  input  logic                     btn_reset,
  input  logic                     game_tick,
  input  logic                     game_over,
  output logic [1:0]               cur_dir,
  output logic                     dir_changed,
  output logic                     dir_dropped,
  output logic [1:0]               game_state,
  output logic                     run,
  output logic                     game_reset,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int CW = $clog2(QDEPTH) + 1;

  state_t        state_r,       state_nxt_s;
  logic [1:0]    cur_dir_r,     cur_dir_nxt_s;
  logic          changed_r,     changed_nxt_s;
  logic          dropped_r,     dropped_nxt_s;
  logic          greset_r,      greset_nxt_s;
  logic          run_r,         run_nxt_s;

  logic          sp_s, rst_ev_s, dir_v_s, dual_s, accept_s, full_s, nonempty_s;
  logic [1:0]    dir_s, ref_s;
  logic          push_s, pop_s, flush_s;
  logic [1:0]    head_s, tail_s;
  logic [CW-1:0] count_s;

  dir_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (flush_s),
    .wr_dir  (dir_s),
    .head    (head_s),
    .tail    (tail_s),
    .count   (count_s)
  );

  // Source merge and direction filter (reference is the pre-pop tail).
  always_comb begin
    sp_s       = kb_start_pause | btn_start_pause;
    rst_ev_s   = kb_reset | btn_reset;
    dir_v_s    = kb_dir_valid | btn_dir_valid;
    dual_s     = kb_dir_valid & btn_dir_valid;
    dir_s      = kb_dir_valid ? kb_dir : btn_dir;
    nonempty_s = (count_s != CW'(0));
    full_s     = (count_s == CW'(QDEPTH));
    ref_s      = nonempty_s ? tail_s : cur_dir_r;
    accept_s   = dir_v_s && (dir_s != ref_s) && (dir_s != opposite(ref_s));
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cur_dir_r <= DIR_RIGHT;
      changed_r <= 1'b0;
      dropped_r <= 1'b0;
      greset_r  <= 1'b0;
      run_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cur_dir_r <= cur_dir_nxt_s;
      changed_r <= changed_nxt_s;
      dropped_r <= dropped_nxt_s;
      greset_r  <= greset_nxt_s;
      run_r     <= run_nxt_s;
    end
  end

  // Next state, queue control and next outputs; priority reset > game_over > start_pause > dir/tick.
  always_comb begin
    state_nxt_s   = state_r;
    cur_dir_nxt_s = cur_dir_r;
    changed_nxt_s = 1'b0;
    dropped_nxt_s = 1'b0;
    greset_nxt_s  = 1'b0;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    flush_s       = 1'b0;
    if (rst_ev_s) begin
      state_nxt_s   = ST_IDLE;
      flush_s       = 1'b1;
      cur_dir_nxt_s = DIR_RIGHT;
      greset_nxt_s  = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sp_s) begin
            state_nxt_s  = ST_RUN;
            greset_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (game_over) begin
            state_nxt_s = ST_OVER;
            flush_s     = 1'b1;
          end else if (sp_s) begin
            state_nxt_s = ST_PAUSE;
          end else begin
            if (game_tick && nonempty_s) begin
              pop_s         = 1'b1;
              cur_dir_nxt_s = head_s;
              changed_nxt_s = 1'b1;
            end else begin
              pop_s = 1'b0;
            end
            if (accept_s) begin
              if (!full_s || pop_s) begin
                push_s = 1'b1;
              end else begin
                dropped_nxt_s = 1'b1;
              end
            end else begin
              push_s = 1'b0;
            end
            if (dual_s) begin
              dropped_nxt_s = 1'b1;
            end else begin
              dropped_nxt_s = dropped_nxt_s;
            end
          end
        end
        ST_PAUSE: begin
          if (sp_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            if (accept_s) begin
              if (!full_s) begin
                push_s = 1'b1;
              end else begin
                dropped_nxt_s = 1'b1;
              end
            end else begin
              push_s = 1'b0;
            end
            if (dual_s) begin
              dropped_nxt_s = 1'b1;
            end else begin
              dropped_nxt_s = dropped_nxt_s;
            end
          end
        end
        ST_OVER: begin
          if (sp_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_OVER;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          flush_s     = 1'b1;
        end
      endcase
    end
    run_nxt_s = (state_nxt_s == ST_RUN);
  end

  assign cur_dir     = cur_dir_r;
  assign dir_changed = changed_r;
  assign dir_dropped = dropped_r;
  assign game_state  = state_r;
  assign run         = run_r;
  assign game_reset  = greset_r;
  assign q_count     = count_s;

endmodule

// File: tb/tb_snake_input_scheduler.sv
module tb_snake_input_scheduler;

  localparam int QDEPTH = 2;
  localparam int CW     = $clog2(QDEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    kb_dir, btn_dir;
  logic          kb_dir_valid, kb_start_pause, kb_reset;
  logic          btn_dir_valid, btn_start_pause, btn_reset;
  logic          game_tick, game_over;
  logic [1:0]    cur_dir, game_state;
  logic          dir_changed, dir_dropped, run, game_reset;
  logic [CW-1:0] q_count;

  always #5 clk = ~clk;

  snake_input_scheduler #(.QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .kb_dir(kb_dir), .kb_dir_valid(kb_dir_valid),
    .kb_start_pause(kb_start_pause), .kb_reset(kb_reset),
    .btn_dir(btn_dir), .btn_dir_valid(btn_dir_valid),
    .btn_start_pause(btn_start_pause), .btn_reset(btn_reset),
    .game_tick(game_tick), .game_over(game_over),
    .cur_dir(cur_dir), .dir_changed(dir_changed), .dir_dropped(dir_dropped),
    .game_state(game_state), .run(run), .game_reset(game_reset),
    .q_count(q_count)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: state number, applied direction, a queue of pending directions.
  int         m_state;   // 0 idle, 1 run, 2 pause, 3 over
  logic [1:0] m_dir;
  logic [1:0] mq[$];
  logic       e_changed, e_dropped, e_greset;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_dir = 2'b11; mq.delete();
    e_changed = 1'b0; e_dropped = 1'b0; e_greset = 1'b0;
  endtask

  // Apply the game rules to the inputs present at this clock edge.
  task automatic model_step();
    logic       sp, rs, dv, do_pop, do_push;
    logic [1:0] d, r;
    sp = kb_start_pause | btn_start_pause;
    rs = kb_reset | btn_reset;
    dv = kb_dir_valid | btn_dir_valid;
    d  = kb_dir_valid ? kb_dir : btn_dir;
    e_changed = 1'b0; e_dropped = 1'b0; e_greset = 1'b0;
    if (rs) begin
      m_state = 0; mq.delete(); m_dir = 2'b11; e_greset = 1'b1;
    end else if (m_state == 1 && game_over) begin
      m_state = 3; mq.delete();
    end else if (sp) begin
      if (m_state == 0) e_greset = 1'b1;
      m_state = (m_state == 0) ? 1 : (m_state == 1) ? 2 : (m_state == 2) ? 1 : 0;
    end else if (m_state == 1 || m_state == 2) begin
      do_pop  = (m_state == 1) && game_tick && (mq.size() > 0);
      do_push = 1'b0;
      if (kb_dir_valid && btn_dir_valid) e_dropped = 1'b1;
      r = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
      if (dv && d != r && d != (r ^ 2'b01)) begin
        if (mq.size() < QDEPTH || do_pop) do_push = 1'b1;
        else e_dropped = 1'b1;
      end
      if (do_pop) begin
        m_dir = mq.pop_front();
        e_changed = 1'b1;
      end
      if (do_push) mq.push_back(d);
    end
  endtask

  task automatic compare_all();
    chk("game_state",  game_state,  m_state);
    chk("run",         run,         (m_state == 1));
    chk("cur_dir",     cur_dir,     m_dir);
    chk("q_count",     q_count,     mq.size());
    chk("dir_changed", dir_changed, e_changed);
    chk("dir_dropped", dir_dropped, e_dropped);
    chk("game_reset",  game_reset,  e_greset);
  endtask

  // One clock: drive pulses, take the edge, update the model, compare.
  task automatic step(input logic [1:0] kd, input logic kv, input logic ksp, input logic kr,
                      input logic [1:0] bd, input logic bv, input logic bsp, input logic br,
                      input logic tk, input logic go);
    kb_dir = kd; kb_dir_valid = kv; kb_start_pause = ksp; kb_reset = kr;
    btn_dir = bd; btn_dir_valid = bv; btn_start_pause = bsp; btn_reset = br;
    game_tick = tk; game_over = go;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();                  step(2'b00,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0); endtask
  task automatic sp_kb();                 step(2'b00,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0); endtask
  task automatic kdir(input logic [1:0] d, input logic tk);
                                          step(d,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,tk,1'b0); endtask
  task automatic tick();                  step(2'b00,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0); endtask

  initial begin
    reset_n = 1'b0;
    kb_dir = 2'b00; kb_dir_valid = 1'b0; kb_start_pause = 1'b0; kb_reset = 1'b0;
    btn_dir = 2'b00; btn_dir_valid = 1'b0; btn_start_pause = 1'b0; btn_reset = 1'b0;
    game_tick = 1'b0; game_over = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", game_state, 2'b00);
    chk("rst_dir",   cur_dir,    2'b11);
    chk("rst_qcnt",  q_count,    0);
    compare_all();
    reset_n = 1'b1;
    idle();

    // Start: game_reset pulse and RUN one edge later.
    sp_kb();
    chk("start_state",  game_state, 2'b01);
    chk("start_greset", game_reset, 1'b1);
    chk("start_dir",    cur_dir,    2'b11);

    // Opposite and same as cur_dir are silently rejected.
    kdir(2'b10, 1'b0);
    kdir(2'b11, 1'b0);
    chk("rej_qcnt",    q_count,     0);
    chk("rej_dropped", dir_dropped, 1'b0);

    // Two queued turns applied one per tick, in order.
    kdir(2'b00, 1'b0);
    kdir(2'b10, 1'b0);
    chk("q2_qcnt", q_count, 2);
    tick();
    chk("t1_dir", cur_dir, 2'b00);
    chk("t1_chg", dir_changed, 1'b1);
    tick();
    chk("t2_dir", cur_dir, 2'b10);
    chk("t2_qcnt", q_count, 0);
    tick();
    chk("t3_nochg", dir_changed, 1'b0);

    // Full queue {00,10}: push 01 drops, push 01 with a tick is accepted.
    kdir(2'b00, 1'b0);
    kdir(2'b10, 1'b0);
    kdir(2'b01, 1'b0);
    chk("full_drop", dir_dropped, 1'b1);
    chk("full_qcnt", q_count, 2);
    kdir(2'b01, 1'b1);
    chk("pp_dir",  cur_dir, 2'b00);
    chk("pp_qcnt", q_count, 2);
    chk("pp_nodrop", dir_dropped, 1'b0);
    tick(); tick();

    // Same-cycle keyboard and button directions: keyboard queued, button dropped.
    kdir(2'b10, 1'b0);
    tick();
    step(2'b00,1'b1,1'b0,1'b0,2'b10,1'b1,1'b0,1'b0,1'b0,1'b0);
    chk("dual_qcnt", q_count, 1);
    chk("dual_drop", dir_dropped, 1'b1);

    // game_over beats start_pause; OVER flushes; reset returns to IDLE.
    kdir(2'b01, 1'b0);
    step(2'b00,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1);
    chk("over_state", game_state, 2'b11);
    chk("over_qcnt",  q_count, 0);
    step(2'b00,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0);
    chk("kr_state",  game_state, 2'b00);
    chk("kr_greset", game_reset, 1'b1);
    chk("kr_dir",    cur_dir, 2'b11);

    // IDLE ignores directions; PAUSE queues but ignores ticks; button paths.
    kdir(2'b00, 1'b1);
    step(2'b00,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0);
    sp_kb();
    step(2'b00,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,1'b1,1'b0);
    chk("pause_qcnt", q_count, 1);
    chk("pause_dir",  cur_dir, 2'b11);
    sp_kb();
    tick();
    chk("resume_dir", cur_dir, 2'b00);

    // Asynchronous reset mid-operation with a queued entry.
    kdir(2'b10, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_qcnt",  q_count, 0);
    chk("arst_state", game_state, 2'b00);
    model_reset();
    @(posedge clk); #1;
    compare_all();
    #2 reset_n = 1'b1;
    idle();
    step(2'b00,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0);
    sp_kb();

    // Soak: mixed pulses against the model.
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0,3)), ($urandom_range(0,2) == 0), ($urandom_range(0,9) == 0),
           ($urandom_range(0,39) == 0), 2'($urandom_range(0,3)), ($urandom_range(0,3) == 0),
           ($urandom_range(0,19) == 0), ($urandom_range(0,59) == 0),
           ($urandom_range(0,2) == 0), ($urandom_range(0,29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
